diamond_checker: RTL and testbench
==================================

# diamond_checker

Consumes a tokenized diamond-pattern stream and checks it against the expected shape for a configured height `n`. Each row `i` is `n-i` blanks, then `i` digit tokens of value `i`, then a newline. Rows rise 1..n and fall n-1..1. The block is the receive/verify end of the diamond-pattern generator. It sits on the generator's token output and reports pass or fail, plus the location of the first fault.

## Interface
Parameters:
- `TOKW`, default 2: token-class width.
- `VALW`, default 4: digit-value and `n` width; `n` max is 15.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  1-cycle pulse; latches `n`, begins a check.
- `n`  in  VALW  diamond height, sampled on accepted `start`.
- `tok_valid`  in  1  token present.
- `tok_ready`  out  1  block accepts the token this cycle.
- `tok_code`  in  TOKW  token class: 0 = BLANK, 1 = DIGIT, 2 = NEWLINE, 3 = reserved.
- `tok_val`  in  VALW  digit value; don't-care unless DIGIT.
- `busy`  out  1  check in progress.
- `done`  out  1  check finished; level, held until next `start`.
- `pass`  out  1  finished with no error; valid while `done`.
- `err_code`  out  2  0 = none, 1 = wrong token class, 2 = wrong digit value, 3 = bad config.
- `err_row`  out  5  row (1..2n-1) of first fault.
- `err_col`  out  4  0-based token position within that row.

## Operation
- States:
  - IDLE
  - LEAD: expect BLANK.
  - DIGS: expect DIGIT.
  - EOL: expect NEWLINE.
  - DONE
  - ERR
- Row arithmetic, for row `r` in 1..2n-1:
  - `i = (r <= n) ? r : 2n-r`
  - `lead = n-i`
  - Computed at 5-bit width; there is no overflow for n ≤ 15.
- Accepting `start`:
  - `start` is accepted in IDLE, DONE and ERR, and ignored while `busy`.
  - On accept, clear `done`, `pass`, `err_*` and set `r = 1`, col = 0.
  - If `n == 0`, go to ERR with `err_code = 3`.
  - Otherwise go to LEAD if `lead > 0`, else DIGS.
- Token acceptance:
  - A token is consumed on `tok_valid && tok_ready`.
  - `tok_ready = 1` only in LEAD, DIGS and EOL.
  - col increments per consumed token.
- LEAD: BLANK accepted. After `lead` blanks, go to DIGS.
- DIGS:
  - DIGIT with `tok_val == i` accepted.
  - DIGIT with any other value → ERR, code 2.
  - After `i` digits, go to EOL.
- EOL: NEWLINE accepted.
  - If `r == 2n-1`, go to DONE with `pass = 1`.
  - Else `r++`, col = 0, then LEAD or DIGS per the new `lead` (zero lead skips LEAD).
- Class errors: any token whose class differs from the expected class → ERR, code 1. This includes reserved code 3.
- On any ERR:
  - `err_row` = current `r`, `err_col` = current col; the offending token is consumed.
  - `done = 1`, `pass = 0`.
  - Only the first error is recorded.
- Reset mid-operation: all state returns to IDLE with reset values immediately. No partial result is retained.

## Timing
- Reset values:
  - `tok_ready = 0`, `busy = 0`, `done = 0`, `pass = 0`.
  - `err_code = 0`, `err_row = 0`, `err_col = 0`.
- `busy` rises the cycle after `start`.
- `tok_ready` first asserts the cycle after `start`. A token presented in the `start` cycle is not consumed.
- Throughput: one token per cycle; `tok_valid` gaps stall without effect.
- `done`/`pass`/`err_*` are registered, valid the cycle after the final or offending token is consumed. `tok_ready` and `busy` drop in that same cycle.
- Total tokens for a passing check: `(n+1)*(2n-1)`.
- `start` coinciding with a consumed token in DONE or ERR: not possible, since `tok_ready = 0` there. `start` wins.

## Configuration
- `DIAMOND_CHK_COUNT_EN` defined:
  - Adds output `tok_count` [8:0], the number of tokens consumed since the last `start`.
  - Cleared on `start` and reset, holds after DONE/ERR.
  - Maximum is 464 at n = 15.
- Undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- Package `diamond_pkg`:
  - Token class constants: BLANK, DIGIT, NEWLINE.
  - Error code constants.
  - State enum.
  - `ROW_W = 5`.
- Sub-module `diamond_row_calc`: combinational; inputs `n`, `r`; outputs `i` and `lead`. Shared with the generator side.

## Test plan
- n=5, correct stream of 54 tokens → `done = 1`, `pass = 1`, `err_code = 0` one cycle after token 54; with count enabled, `tok_count = 54`.
- n=1, stream DIGIT(1), NEWLINE → `pass = 1` after 2 tokens; no BLANK is ever expected.
- n=3, row 2 second token DIGIT(3) → `err_code = 2`, `err_row = 2`, `err_col = 1`; `tok_ready` low next cycle.
- n=4, row 1 begins with DIGIT(1) → `err_code = 1`, `err_row = 1`, `err_col = 0`.
- `start` with n=0 → `err_code = 3`, `done = 1`, `pass = 0` next cycle; zero tokens consumed.
- n=5 stream with random `tok_valid` gaps, `rst_n` pulsed low during row 3 → all outputs at reset values. Then `start` with n=2 and 9 correct tokens → `pass = 1`.

Source files
------------

// File: rtl/diamond_pkg.sv
// diamond_pkg
//   Shared definitions for the diamond-pattern checker and generator.
//   Contents: token class codes, error codes, checker state enum,
//   row/column/count widths and the registered result record.
package diamond_pkg;

    localparam int ROW_W = 5;   // rows 1..2n-1, n <= 15 -> up to 29
    localparam int COL_W = 4;   // column 0..n within a row
    localparam int CNT_W = 9;   // tokens per check, max 464

    // Token classes
    localparam logic [1:0] TOK_BLANK   = 2'd0;
    localparam logic [1:0] TOK_DIGIT   = 2'd1;
    localparam logic [1:0] TOK_NEWLINE = 2'd2;

    // Error codes
    localparam logic [1:0] ERR_NONE   = 2'd0;
    localparam logic [1:0] ERR_CLASS  = 2'd1;
    localparam logic [1:0] ERR_VALUE  = 2'd2;
    localparam logic [1:0] ERR_CONFIG = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEAD,
        ST_DIGS,
        ST_EOL,
        ST_DONE,
        ST_ERR
    } state_t;

    // Everything reported back once a check finishes
    typedef struct packed {
        logic             done;
        logic             pass;
        logic [1:0]       err_code;
        logic [ROW_W-1:0] err_row;
        logic [COL_W-1:0] err_col;
    } result_t;

endpackage

// File: rtl/diamond_row_calc.sv
// diamond_row_calc
//   Combinational row geometry for a diamond of height n.
//   Row r (1..2n-1) carries i digits preceded by lead = n-i blanks, where
//   i = r on the rising half and 2n-r on the falling half.
// Ports:
//   n    in  VALW   diamond height
//   r    in  ROW_W  1-based row number
//   i    out ROW_W  digit count (and digit value) of row r
//   lead out ROW_W  leading blank count of row r
module diamond_row_calc
    import diamond_pkg::*;
#(
    parameter int VALW = 4
) (
    input  logic [VALW-1:0]  n,
    input  logic [ROW_W-1:0] r,
    output logic [ROW_W-1:0] i,
    output logic [ROW_W-1:0] lead
);

    logic [ROW_W-1:0] n_w;

    // 5 bits hold 2n = 30 for n = 15, so no term below overflows
    assign n_w = ROW_W'(n);

    always_comb begin
        i    = (r <= n_w) ? r : ((n_w << 1) - r);
        lead = n_w - i;
    end

endmodule

// File: rtl/diamond_checker.sv
// diamond_checker
//   Verifies a tokenized diamond-pattern stream against the shape implied
//   by height n and reports pass/fail plus the location of the first fault.
//   Optional feature macro: DIAMOND_CHK_COUNT_EN adds the tok_count output.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, n            start pulse and diamond height (sampled on start)
//   tok_valid/ready     token handshake, consumed when both high
//   tok_code, tok_val   token class and digit value
//   busy                check in progress
//   done, pass          finished / finished without error (level)
//   err_code            0 none, 1 class, 2 value, 3 bad config
//   err_row, err_col    row (1-based) and column (0-based) of first fault
//   tok_count           tokens consumed since start (DIAMOND_CHK_COUNT_EN)
module diamond_checker
    import diamond_pkg::*;
#(
    parameter int TOKW = 2,
    parameter int VALW = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [VALW-1:0] n,
    input  logic            tok_valid,
    output logic            tok_ready,
    input  logic [TOKW-1:0] tok_code,
    input  logic [VALW-1:0] tok_val,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [1:0]      err_code,
`ifdef DIAMOND_CHK_COUNT_EN
    output logic [8:0]      tok_count,
`endif
    output logic [4:0]      err_row,
    output logic [3:0]      err_col
);

    state_t           state;
    logic [VALW-1:0]  n_q;
    logic [ROW_W-1:0] r;
    logic [COL_W-1:0] col;
    logic             tok_ready_q;
    logic             busy_q;
    result_t          res;

    logic             accept;
    logic             fire;
    logic [VALW-1:0]  calc_n;
    logic [ROW_W-1:0] calc_r;
    logic [ROW_W-1:0] calc_i;
    logic [ROW_W-1:0] calc_lead;
    logic [ROW_W-1:0] col_nx;
    logic [ROW_W-1:0] last_row;
    logic             lead_last;
    logic             digs_last;
    logic             row_last;
    logic [1:0]       tok_err;

    assign accept = start && (state == ST_IDLE || state == ST_DONE || state == ST_ERR);
    assign fire   = tok_valid && tok_ready_q;

    // One row calculator serves three purposes: the first row when a start
    // is accepted, the following row while sitting in EOL (so the next
    // LEAD/DIGS choice is ready when the newline lands), and the current
    // row in LEAD/DIGS.
    always_comb begin
        calc_n = n_q;
        calc_r = r;
        if (accept) begin
            calc_n = n;
            calc_r = ROW_W'(1);
        end else if (state == ST_EOL) begin
            calc_r = r + ROW_W'(1);
        end
    end

    diamond_row_calc #(
        .VALW (VALW)
    ) u_row_calc (
        .n    (calc_n),
        .r    (calc_r),
        .i    (calc_i),
        .lead (calc_lead)
    );

    // Column bookkeeping: col counts tokens already consumed in this row,
    // so the token in flight is the last of its phase when col+1 reaches
    // the phase boundary.
    assign col_nx    = ROW_W'(col) + ROW_W'(1);
    assign lead_last = (col_nx == calc_lead);
    assign digs_last = (col_nx == calc_lead + calc_i);
    assign last_row  = (ROW_W'(n_q) << 1) - ROW_W'(1);
    assign row_last  = (r == last_row);

    // Classify the token in flight against what the current state expects
    always_comb begin
        tok_err = ERR_NONE;
        unique case (state)
            ST_LEAD: if (tok_code != TOKW'(TOK_BLANK)) tok_err = ERR_CLASS;
            ST_DIGS: begin
                if (tok_code != TOKW'(TOK_DIGIT))
                    tok_err = ERR_CLASS;
                else if (ROW_W'(tok_val) != calc_i)
                    tok_err = ERR_VALUE;
            end
            ST_EOL:  if (tok_code != TOKW'(TOK_NEWLINE)) tok_err = ERR_CLASS;
            default: tok_err = ERR_NONE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            n_q         <= '0;
            r           <= '0;
            col         <= '0;
            tok_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            res         <= '0;
        end else if (accept) begin
            n_q <= n;
            r   <= ROW_W'(1);
            col <= '0;
            res <= '0;
            if (n == '0) begin
                // Height zero is not a diamond; finish immediately
                state        <= ST_ERR;
                tok_ready_q  <= 1'b0;
                busy_q       <= 1'b0;
                res.done     <= 1'b1;
                res.err_code <= ERR_CONFIG;
                res.err_row  <= ROW_W'(1);
            end else begin
                state       <= (calc_lead != '0) ? ST_LEAD : ST_DIGS;
                tok_ready_q <= 1'b1;
                busy_q      <= 1'b1;
            end
        end else if (fire) begin
            col <= col + COL_W'(1);
            if (tok_err != ERR_NONE) begin
                // The offending token is consumed; location is where it sat
                state        <= ST_ERR;
                tok_ready_q  <= 1'b0;
                busy_q       <= 1'b0;
                res.done     <= 1'b1;
                res.pass     <= 1'b0;
                res.err_code <= tok_err;
                res.err_row  <= r;
                res.err_col  <= col;
            end else begin
                unique case (state)
                    ST_LEAD: if (lead_last) state <= ST_DIGS;
                    ST_DIGS: if (digs_last) state <= ST_EOL;
                    ST_EOL: begin
                        if (row_last) begin
                            state       <= ST_DONE;
                            tok_ready_q <= 1'b0;
                            busy_q      <= 1'b0;
                            res.done    <= 1'b1;
                            res.pass    <= 1'b1;
                        end else begin
                            // calc_* already describe row r+1 here
                            r     <= r + ROW_W'(1);
                            col   <= '0;
                            state <= (calc_lead != '0) ? ST_LEAD : ST_DIGS;
                        end
                    end
                    default: state <= state;
                endcase
            end
        end
    end

`ifdef DIAMOND_CHK_COUNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else if (accept)
            cnt_q <= '0;
        else if (fire)
            cnt_q <= cnt_q + CNT_W'(1);
    end

    assign tok_count = cnt_q;
`endif

    assign tok_ready = tok_ready_q;
    assign busy      = busy_q;
    assign done      = res.done;
    assign pass      = res.pass;
    assign err_code  = res.err_code;
    assign err_row   = res.err_row;
    assign err_col   = res.err_col;

endmodule

// File: tb/tb_diamond_checker.sv
// tb_diamond_checker
//   Directed table of vectors plus randomized streams for diamond_checker.
//   Expected results come from a token-list model: the ideal diamond is
//   written out as a list of (class, value, row, col) and the first
//   difference against the sent stream decides the outcome.
//   Honours DIAMOND_CHK_COUNT_EN for the tok_count port.
module tb_diamond_checker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] n;
    logic       tok_valid;
    logic       tok_ready;
    logic [1:0] tok_code;
    logic [3:0] tok_val;
    logic       busy;
    logic       done;
    logic       pass;
    logic [1:0] err_code;
    logic [4:0] err_row;
    logic [3:0] err_col;
`ifdef DIAMOND_CHK_COUNT_EN
    logic [8:0] tok_count;
`endif

    always #5 clk = ~clk;

    diamond_checker #(.TOKW(2), .VALW(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .n         (n),
        .tok_valid (tok_valid),
        .tok_ready (tok_ready),
        .tok_code  (tok_code),
        .tok_val   (tok_val),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_code  (err_code),
`ifdef DIAMOND_CHK_COUNT_EN
        .tok_count (tok_count),
`endif
        .err_row   (err_row),
        .err_col   (err_col)
    );

    typedef struct { int code; int val; int row; int col; } tok_t;
    typedef struct { int n; int idx; int code; int val;
                     int ps; int ec; int er; int ecol; int cnt; } vec_t;

    tok_t exp_q[$];
    tok_t sent_q[$];
    vec_t vt[8];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Ideal token list for height nn
    function automatic void build_exp(input int nn);
        exp_q.delete();
        for (int r = 1; r <= 2*nn-1; r++) begin
            int i;
            int c;
            i = (r <= nn) ? r : 2*nn - r;
            c = 0;
            for (int b = 0; b < nn-i; b++) begin exp_q.push_back('{0, 0, r, c}); c++; end
            for (int d = 0; d < i; d++)     begin exp_q.push_back('{1, i, r, c}); c++; end
            exp_q.push_back('{2, 0, r, c});
        end
    endfunction

    // Sent stream = ideal stream, with junk values on non-digit tokens
    function automatic void build_sent();
        sent_q.delete();
        foreach (exp_q[k]) begin
            tok_t t;
            t = exp_q[k];
            if (t.code != 1) t.val = int'($urandom_range(0, 15));
            sent_q.push_back(t);
        end
    endfunction

    task automatic model(output int m_ps, output int m_ec, output int m_er,
                         output int m_col, output int m_cnt);
        m_ps = 1; m_ec = 0; m_er = 0; m_col = 0; m_cnt = exp_q.size();
        for (int k = 0; k < exp_q.size(); k++) begin
            int e;
            e = 0;
            if (sent_q[k].code != exp_q[k].code) e = 1;
            else if (sent_q[k].code == 1 && sent_q[k].val != exp_q[k].val) e = 2;
            if (e != 0) begin
                m_ps = 0; m_ec = e; m_er = exp_q[k].row; m_col = exp_q[k].col; m_cnt = k + 1;
                return;
            end
        end
    endtask

    // Called at a negedge; returns at the following negedge. A bait token
    // is offered in the start cycle and must not be taken.
    task automatic do_start(input int nn);
        start = 1'b1; n = 4'(nn);
        tok_valid = 1'b1; tok_code = 2'd1; tok_val = 4'(nn);
        chk("ready_in_start_cycle", int'(tok_ready), 0);
        @(negedge clk);
        start = 1'b0; tok_valid = 1'b0;
    endtask

    // Offer sent_q[from..stop-1] with random gaps; stops early on done
    task automatic feed(input int from, input int stop, input int gap,
                        output int consumed);
        int k;
        int cyc;
        k = from; cyc = 0;
        forever begin
            if (k >= stop || done) break;
            if (cyc >= 4000) begin
                chk("feed_timeout", 1, 0);
                break;
            end
            tok_valid = ($urandom_range(0, 99) >= gap);
            tok_code  = 2'(sent_q[k].code);
            tok_val   = 4'(sent_q[k].val);
            if (tok_valid && tok_ready) k++;
            @(negedge clk);
            cyc++;
        end
        tok_valid = 1'b0;
        consumed = k;
    endtask

    task automatic wait_done();
        for (int w = 0; w < 8 && !done; w++) @(negedge clk);
        chk("done_seen", int'(done), 1);
    endtask

    task automatic check_result(input string tag, input int ps, input int ec,
                                input int er, input int ecol, input int cnt,
                                input int consumed);
        chk({tag, ".done"},     int'(done), 1);
        chk({tag, ".pass"},     int'(pass), ps);
        chk({tag, ".err_code"}, int'(err_code), ec);
        chk({tag, ".err_row"},  int'(err_row), er);
        chk({tag, ".err_col"},  int'(err_col), ecol);
        chk({tag, ".busy"},     int'(busy), 0);
        chk({tag, ".ready"},    int'(tok_ready), 0);
        chk({tag, ".consumed"}, consumed, cnt);
`ifdef DIAMOND_CHK_COUNT_EN
        chk({tag, ".tok_count"}, int'(tok_count), cnt);
`endif
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, ".ready"},    int'(tok_ready), 0);
        chk({tag, ".busy"},     int'(busy), 0);
        chk({tag, ".done"},     int'(done), 0);
        chk({tag, ".pass"},     int'(pass), 0);
        chk({tag, ".err_code"}, int'(err_code), 0);
        chk({tag, ".err_row"},  int'(err_row), 0);
        chk({tag, ".err_col"},  int'(err_col), 0);
`ifdef DIAMOND_CHK_COUNT_EN
        chk({tag, ".tok_count"}, int'(tok_count), 0);
`endif
    endtask

    initial begin
        int got;
        int m_ps, m_ec, m_er, m_col, m_cnt;

        //        n  idx code val  pass ec row col  cnt
        vt[0] = '{5,  -1, 0, 0,   1,  0, 0,  0,  54};
        vt[1] = '{1,  -1, 0, 0,   1,  0, 0,  0,   2};
        vt[2] = '{3,   5, 1, 3,   0,  2, 2,  1,   6};
        vt[3] = '{4,   0, 1, 1,   0,  1, 1,  0,   1};
        vt[4] = '{2,   2, 0, 0,   0,  1, 1,  2,   3};
        vt[5] = '{3,  19, 3, 0,   0,  1, 5,  3,  20};
        vt[6] = '{2,   4, 1, 1,   0,  2, 2,  1,   5};
        vt[7] = '{15, -1, 0, 0,   1,  0, 0,  0, 464};

        rst_n = 1'b0; start = 1'b0; n = '0;
        tok_valid = 1'b0; tok_code = '0; tok_val = '0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Directed table
        foreach (vt[v]) begin
            build_exp(vt[v].n);
            build_sent();
            if (vt[v].idx >= 0) begin
                sent_q[vt[v].idx].code = vt[v].code;
                sent_q[vt[v].idx].val  = vt[v].val;
            end
            do_start(vt[v].n);
            chk($sformatf("vec%0d.busy_after_start", v), int'(busy), 1);
            feed(0, sent_q.size(), (v % 2) * 30, got);
            wait_done();
            check_result($sformatf("vec%0d", v), vt[v].ps, vt[v].ec,
                         vt[v].er, vt[v].ecol, vt[v].cnt, got);
        end

        // Height zero: immediate config error, nothing consumed
        do_start(0);
        chk("n0.done", int'(done), 1);
        chk("n0.pass", int'(pass), 0);
        chk("n0.err_code", int'(err_code), 3);
        chk("n0.busy", int'(busy), 0);
        tok_valid = 1'b1;
        repeat (2) begin
            chk("n0.ready", int'(tok_ready), 0);
            @(negedge clk);
        end
        tok_valid = 1'b0;
`ifdef DIAMOND_CHK_COUNT_EN
        chk("n0.tok_count", int'(tok_count), 0);
`endif

        // start while busy is ignored
        build_exp(3);
        build_sent();
        do_start(3);
        feed(0, 5, 0, got);
        start = 1'b1; n = 4'd7;
        @(negedge clk);
        start = 1'b0;
        chk("busy_start.busy", int'(busy), 1);
        feed(got, sent_q.size(), 20, got);
        wait_done();
        check_result("busy_start", 1, 0, 0, 0, 20, got);

        // Reset in the middle of row 3, then a clean n=2 check
        build_exp(5);
        build_sent();
        do_start(5);
        feed(0, 14, 30, got);
        chk("midrst.busy_before", int'(busy), 1);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        build_exp(2);
        build_sent();
        do_start(2);
        feed(0, sent_q.size(), 0, got);
        wait_done();
        check_result("after_rst", 1, 0, 0, 0, 9, got);

        // Randomized streams against the token-list model
        for (int t = 0; t < 40; t++) begin
            int nn;
            nn = int'($urandom_range(1, 15));
            build_exp(nn);
            build_sent();
            if ($urandom_range(0, 2) != 0) begin
                int idx;
                idx = int'($urandom_range(0, sent_q.size() - 1));
                sent_q[idx].code = int'($urandom_range(0, 3));
                sent_q[idx].val  = int'($urandom_range(0, 15));
            end
            model(m_ps, m_ec, m_er, m_col, m_cnt);
            do_start(nn);
            feed(0, sent_q.size(), int'($urandom_range(0, 50)), got);
            wait_done();
            check_result($sformatf("rand%0d_n%0d", t, nn), m_ps, m_ec, m_er, m_col, m_cnt, got);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
